// File: rtl/execute_mdu_stage.sv
// Registered execute stage with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ALU ops complete on the transfer edge; MULT/DIV ops stall the pipeline for DATA_W cycles.
module execute_mdu_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SHAMT_W    = 5,
    parameter int INDEX_W    = 26
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  Stall,
    input  logic [3:0]            ALUOp,
    input  logic                  ALUSrc1,
    input  logic                  RegDst,
    input  logic                  RegWrite_in,
    input  logic [SHAMT_W-1:0]    Shamt,
    input  logic [DATA_W-1:0]     Reg_Data1,
    input  logic [DATA_W-1:0]     Reg_Data2,
    input  logic [DATA_W-1:0]     Imm32b,
    input  logic [DATA_W-1:0]     PCPlusFour,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [INDEX_W-1:0]    instr_index,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     ALUResult,
    output logic                  Zero,
    output logic [DATA_W-1:0]     PC_Plus_Branch,
    output logic [INDEX_W+1:0]    j_sll_two,
    output logic [REG_ADDR_W-1:0] RegDestSelected,
    output logic                  RegWrite_out,
    output logic [DATA_W-1:0]     HI,
    output logic [DATA_W-1:0]     LO
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB   = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_XOR  = 4'd4,  OP_NOR   = 4'd5,  OP_SLT  = 4'd6,  OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,  OP_SRA   = 4'd9,  OP_MULT = 4'd10, OP_MULTU = 4'd11,
        OP_DIV  = 4'd12, OP_DIVU  = 4'd13, OP_MFHI = 4'd14, OP_MFLO = 4'd15
    } op_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_hiacc;
    logic [DATA_W-1:0]     r_loacc;
    logic [DATA_W-1:0]     r_operand;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_dz;

    op_e                   w_op;
    logic                  w_fire;
    logic                  w_is_mul;
    logic                  w_is_div;
    logic                  w_signed;
    logic                  w_last;
    logic [DATA_W-1:0]     w_a;
    logic [DATA_W-1:0]     w_b;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_W-1:0]     w_a_mag;
    logic [DATA_W-1:0]     w_b_mag;
    logic [DATA_W-1:0]     w_alu;

    logic [DATA_W:0]       w_mul_sum;
    logic [DATA_W-1:0]     w_mul_hi;
    logic [DATA_W-1:0]     w_mul_lo;
    logic [2*DATA_W-1:0]   w_prod_fin;
    logic [DATA_W:0]       w_div_shift;
    logic                  w_div_ge;
    logic [DATA_W-1:0]     w_div_diff;
    logic [DATA_W-1:0]     w_div_rem;
    logic [DATA_W-1:0]     w_div_quo;
    logic [DATA_W-1:0]     w_quo_fin;
    logic [DATA_W-1:0]     w_rem_fin;

    assign w_op     = op_e'(ALUOp);
    assign w_fire   = in_valid && in_ready;
    assign w_is_mul = (w_op == OP_MULT) || (w_op == OP_MULTU);
    assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_last   = (r_cnt == CNT_W'(1));
    assign w_a      = Reg_Data1;
    assign w_b      = ALUSrc1 ? Imm32b : Reg_Data2;
    assign w_a_neg  = w_signed && w_a[DATA_W-1];
    assign w_b_neg  = w_signed && w_b[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -w_a : w_a;
    assign w_b_mag  = w_b_neg ? -w_b : w_b;

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = w_a + w_b;
            OP_SUB:  w_alu = w_a - w_b;
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_NOR:  w_alu = ~(w_a | w_b);
            OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            OP_SLL:  w_alu = w_b << Shamt;
            OP_SRL:  w_alu = w_b >> Shamt;
            OP_SRA:  w_alu = $signed(w_b) >>> Shamt;
            OP_MFHI: w_alu = HI;
            OP_MFLO: w_alu = LO;
            default: w_alu = '0;
        endcase
    end

    // Shift-add step: {hiacc, loacc} holds partial product above the unconsumed multiplier bits.
    assign w_mul_sum  = {1'b0, r_hiacc} + (r_loacc[0] ? {1'b0, r_operand} : '0);
    assign w_mul_hi   = w_mul_sum[DATA_W:1];
    assign w_mul_lo   = {w_mul_sum[0], r_loacc[DATA_W-1:1]};
    assign w_prod_fin = r_neg_q ? -{w_mul_hi, w_mul_lo} : {w_mul_hi, w_mul_lo};

    // Restoring step: hiacc is the partial remainder, loacc shifts dividend bits out and quotient bits in.
    assign w_div_shift = {r_hiacc, r_loacc[DATA_W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_operand});
    assign w_div_diff  = w_div_shift[DATA_W-1:0] - r_operand;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[DATA_W-1:0];
    assign w_div_quo   = {r_loacc[DATA_W-2:0], w_div_ge};
    // A zero divisor naturally yields remainder = |dividend|; only the quotient needs forcing.
    assign w_quo_fin   = r_dz ? '1 : (r_neg_q ? -w_div_quo : w_div_quo);
    assign w_rem_fin   = r_neg_r ? -w_div_rem : w_div_rem;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fire && w_is_mul) begin
                    w_state_next = S_MUL;
                end else if (w_fire && w_is_div) begin
                    w_state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_IDLE);
        Stall    = (r_state != S_IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt           <= '0;
            r_hiacc         <= '0;
            r_loacc         <= '0;
            r_operand       <= '0;
            r_neg_q         <= 1'b0;
            r_neg_r         <= 1'b0;
            r_dz            <= 1'b0;
            out_valid       <= 1'b0;
            ALUResult       <= '0;
            Zero            <= 1'b0;
            PC_Plus_Branch  <= '0;
            j_sll_two       <= '0;
            RegDestSelected <= '0;
            RegWrite_out    <= 1'b0;
            HI              <= '0;
            LO              <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire && (w_is_mul || w_is_div)) begin
                        r_cnt     <= CNT_LOAD;
                        r_hiacc   <= '0;
                        r_loacc   <= w_a_mag;
                        r_operand <= w_b_mag;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_dz      <= w_is_div && (w_b == '0);
                    end else if (w_fire) begin
                        out_valid       <= 1'b1;
                        ALUResult       <= w_alu;
                        Zero            <= (w_alu == '0);
                        PC_Plus_Branch  <= PCPlusFour + (Imm32b << 2);
                        j_sll_two       <= {instr_index, 2'b00};
                        RegDestSelected <= RegDst ? rd : rt;
                        RegWrite_out    <= RegWrite_in;
                    end
                end
                S_MUL, S_DIV: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_state == S_MUL) begin
                        r_hiacc <= w_mul_hi;
                        r_loacc <= w_mul_lo;
                    end else begin
                        r_hiacc <= w_div_rem;
                        r_loacc <= w_div_quo;
                    end
                    if (w_last) begin
                        if (r_state == S_MUL) begin
                            HI <= w_prod_fin[2*DATA_W-1:DATA_W];
                            LO <= w_prod_fin[DATA_W-1:0];
                        end else begin
                            HI <= w_rem_fin;
                            LO <= w_quo_fin;
                        end
                        out_valid       <= 1'b1;
                        ALUResult       <= '0;
                        Zero            <= 1'b1;
                        RegDestSelected <= '0;
                        RegWrite_out    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mdu_stage.sv
// Self-checking bench for execute_mdu_stage: directed scenarios plus randomized ALU and mul/div
// operations checked against a plain-arithmetic reference model.
module tb_execute_mdu_stage;

    localparam int W = 32;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready, Stall;
    logic [3:0]  ALUOp = '0;
    logic        ALUSrc1 = 1'b0, RegDst = 1'b0, RegWrite_in = 1'b0;
    logic [4:0]  Shamt = '0;
    logic [31:0] Reg_Data1 = '0, Reg_Data2 = '0, Imm32b = '0, PCPlusFour = '0;
    logic [4:0]  rt = '0, rd = '0;
    logic [25:0] instr_index = '0;
    logic        out_valid, Zero, RegWrite_out;
    logic [31:0] ALUResult, PC_Plus_Branch, HI, LO;
    logic [27:0] j_sll_two;
    logic [4:0]  RegDestSelected;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    execute_mdu_stage #(.DATA_W(W), .REG_ADDR_W(5), .SHAMT_W(5), .INDEX_W(26)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .Stall(Stall),
        .ALUOp(ALUOp), .ALUSrc1(ALUSrc1), .RegDst(RegDst), .RegWrite_in(RegWrite_in),
        .Shamt(Shamt), .Reg_Data1(Reg_Data1), .Reg_Data2(Reg_Data2), .Imm32b(Imm32b),
        .PCPlusFour(PCPlusFour), .rt(rt), .rd(rd), .instr_index(instr_index),
        .out_valid(out_valid), .ALUResult(ALUResult), .Zero(Zero),
        .PC_Plus_Branch(PC_Plus_Branch), .j_sll_two(j_sll_two),
        .RegDestSelected(RegDestSelected), .RegWrite_out(RegWrite_out), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, b,
                                              input logic [4:0] sh);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd7:  return b << sh;
            4'd8:  return b >> sh;
            4'd9:  return 32'(int'(b) >>> sh);
            4'd14: return m_hi;
            4'd15: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_md(input logic [3:0] op, input logic [31:0] a, b,
                            output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        hi = '0;
        lo = '0;
        if (op == 4'd10) begin
            p = 64'(longint'(ia) * longint'(ib));
            hi = p[63:32]; lo = p[31:0];
        end else if (op == 4'd11) begin
            p = {32'd0, a} * {32'd0, b};
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 4'd12 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = 32'd0; lo = 32'h8000_0000;
        end else if (op == 4'd12) begin
            lo = 32'(ia / ib); hi = 32'(ia % ib);
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, b, imm, pc,
                         input logic src, dst, we, input logic [4:0] sh, t, d,
                         input logic [25:0] idx);
        ALUOp = op; Reg_Data1 = a; Reg_Data2 = b; Imm32b = imm; PCPlusFour = pc;
        ALUSrc1 = src; RegDst = dst; RegWrite_in = we; Shamt = sh; rt = t; rd = d;
        instr_index = idx; in_valid = 1'b1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        n_checks++; if (ALUResult !== 32'd0) begin n_errors++; $display("FAIL reset_result got %h exp 0", ALUResult); end
        n_checks++; if (HI !== 32'd0 || LO !== 32'd0) begin n_errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", HI, LO); end
        n_checks++; if (Stall !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got stall=%0b ready=%0b exp 0/1", Stall, in_ready); end
        n_checks++; if (RegWrite_out !== 1'b0 || Zero !== 1'b0) begin n_errors++; $display("FAIL reset_flags got we=%0b zero=%0b exp 0/0", RegWrite_out, Zero); end
        Reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge Clk);
    endtask

    task automatic test_single(input string nm, input logic [3:0] op, input logic [31:0] a, b, imm, pc,
                               input logic src, dst, we, input logic [4:0] sh, t, d,
                               input logic [25:0] idx);
        logic [31:0] exp_res;
        exp_res = model_alu(op, a, src ? imm : b, sh);
        @(negedge Clk);
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL %s_ready got %0b exp 1", nm, in_ready); end
        drive(op, a, b, imm, pc, src, dst, we, sh, t, d, idx);
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL %s_valid got %0b exp 1", nm, out_valid); end
        n_checks++; if (ALUResult !== exp_res) begin n_errors++; $display("FAIL %s_result op=%0d got %h exp %h", nm, op, ALUResult, exp_res); end
        n_checks++; if (Zero !== (exp_res == 32'd0)) begin n_errors++; $display("FAIL %s_zero got %0b exp %0b", nm, Zero, exp_res == 32'd0); end
        n_checks++; if (RegDestSelected !== (dst ? d : t)) begin n_errors++; $display("FAIL %s_dest got %0d exp %0d", nm, RegDestSelected, dst ? d : t); end
        n_checks++; if (RegWrite_out !== we) begin n_errors++; $display("FAIL %s_we got %0b exp %0b", nm, RegWrite_out, we); end
        n_checks++; if (PC_Plus_Branch !== pc + (imm << 2)) begin n_errors++; $display("FAIL %s_pcb got %h exp %h", nm, PC_Plus_Branch, pc + (imm << 2)); end
        n_checks++; if (j_sll_two !== {idx, 2'b00}) begin n_errors++; $display("FAIL %s_jump got %h exp %h", nm, j_sll_two, {idx, 2'b00}); end
    endtask

    task automatic test_muldiv(input string nm, input logic [3:0] op, input logic [31:0] a, b);
        logic [31:0] eh, el;
        int stall_cnt, spurious;
        model_md(op, a, b, eh, el);
        @(negedge Clk);
        drive(op, a, b, 32'(3), 32'(100), 1'b0, 1'b1, 1'b1, 5'd0, 5'd3, 5'd9, 26'd0);
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        stall_cnt = 0;
        spurious = 0;
        while (Stall === 1'b1 && stall_cnt < 200) begin
            stall_cnt++;
            if (out_valid !== 1'b0) spurious++;
            @(negedge Clk);
        end
        n_checks++; if (stall_cnt != W) begin n_errors++; $display("FAIL %s_stall_cycles got %0d exp %0d", nm, stall_cnt, W); end
        n_checks++; if (spurious != 0) begin n_errors++; $display("FAIL %s_busy_valid got %0d pulses exp 0", nm, spurious); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL %s_done_valid got %0b exp 1", nm, out_valid); end
        n_checks++; if (HI !== eh || LO !== el) begin n_errors++; $display("FAIL %s_hilo a=%h b=%h got %h/%h exp %h/%h", nm, a, b, HI, LO, eh, el); end
        n_checks++; if (ALUResult !== 32'd0 || RegWrite_out !== 1'b0 || RegDestSelected !== 5'd0) begin
            n_errors++; $display("FAIL %s_done_fields got res=%h we=%0b dst=%0d exp 0/0/0", nm, ALUResult, RegWrite_out, RegDestSelected);
        end
        m_hi = eh; m_lo = el;
        @(negedge Clk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL %s_pulse_width got %0b exp 0", nm, out_valid); end
    endtask

    task automatic test_add;
        test_single("add", 4'd0, 32'd108, 32'd112, 32'd15, 32'd4, 1'b0, 1'b1, 1'b1, 5'd0, 5'd2, 5'd16, 26'h0FF_FFFF);
        n_checks++; if (ALUResult !== 32'd220 || PC_Plus_Branch !== 32'd64 || j_sll_two !== 28'h3FF_FFFC || RegDestSelected !== 5'd16) begin
            n_errors++; $display("FAIL add_fixed got %0d/%0d/%h/%0d exp 220/64/3fffffc/16", ALUResult, PC_Plus_Branch, j_sll_two, RegDestSelected);
        end
        @(negedge Clk);
        n_checks++; if (out_valid !== 1'b0 || ALUResult !== 32'd220) begin n_errors++; $display("FAIL add_hold got v=%0b res=%0d exp 0/220", out_valid, ALUResult); end
    endtask

    task automatic test_flags_shifts;
        test_single("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd4, 5'd0, 26'd0);
        n_checks++; if (Zero !== 1'b1) begin n_errors++; $display("FAIL sub_zero_flag got %0b exp 1", Zero); end
        test_single("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd4, 5'd0, 26'd0);
        n_checks++; if (ALUResult !== 32'd1) begin n_errors++; $display("FAIL slt_fixed got %h exp 1", ALUResult); end
        test_single("sra", 4'd9, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 26'd0);
        n_checks++; if (ALUResult !== 32'hF800_0000) begin n_errors++; $display("FAIL sra_fixed got %h exp f8000000", ALUResult); end
        test_single("srl", 4'd8, 32'd0, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 26'd0);
        n_checks++; if (ALUResult !== 32'h0800_0000) begin n_errors++; $display("FAIL srl_fixed got %h exp 08000000", ALUResult); end
    endtask

    task automatic test_mult_div;
        test_muldiv("mult", 4'd10, 32'hFFFF_FFFD, 32'd7);
        n_checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin n_errors++; $display("FAIL mult_fixed got %h/%h exp ffffffff/ffffffeb", HI, LO); end
        test_single("mflo", 4'd15, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd8, 26'd0);
        n_checks++; if (ALUResult !== 32'hFFFF_FFEB) begin n_errors++; $display("FAIL mflo_fixed got %h exp ffffffeb", ALUResult); end
        test_muldiv("div", 4'd12, 32'hFFFF_FFF9, 32'd2);
        n_checks++; if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL div_fixed got %h/%h exp ffffffff/fffffffd", HI, LO); end
        test_muldiv("divu_zero", 4'd13, 32'd7, 32'd0);
        n_checks++; if (LO !== 32'hFFFF_FFFF || HI !== 32'd7) begin n_errors++; $display("FAIL divu_zero_fixed got %h/%h exp 7/ffffffff", HI, LO); end
        test_muldiv("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++; if (LO !== 32'h8000_0000 || HI !== 32'd0) begin n_errors++; $display("FAIL div_ovf_fixed got %h/%h exp 0/80000000", HI, LO); end
        test_muldiv("div_neg_zero", 4'd12, 32'hFFFF_FF00, 32'd0);
        test_single("mfhi", 4'd14, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd6, 5'd0, 26'd0);
    endtask

    task automatic test_reset_mid_op;
        int pulses;
        @(negedge Clk);
        drive(4'd10, 32'd12345, 32'd678, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd1, 5'd2, 26'd0);
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_checks++; if (Stall !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ctrl got stall=%0b v=%0b exp 0/0", Stall, out_valid); end
        n_checks++; if (HI !== 32'd0 || LO !== 32'd0) begin n_errors++; $display("FAIL rst_mid_hilo got %h/%h exp 0/0", HI, LO); end
        @(negedge Clk);
        Reset = 1'b0;
        m_hi = '0; m_lo = '0;
        pulses = 0;
        repeat (W + 4) begin
            @(negedge Clk);
            if (out_valid !== 1'b0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_errors++; $display("FAIL rst_mid_pulse got %0d pulses exp 0", pulses); end
        test_single("add_after_rst", 4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 26'd0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] eh, el;
        int pulses, p1, p2, acc;
        logic fire_pending;
        logic [31:0] r1, r2;
        model_md(4'd13, 32'd1000, 32'd7, eh, el);
        @(negedge Clk);
        drive(4'd13, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd1, 5'd2, 26'd0);
        @(posedge Clk);
        @(negedge Clk);
        drive(4'd1, 32'd50, 32'd8, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd1, 5'd11, 26'd0);
        pulses = 0; p1 = -1; p2 = -1; acc = -1; fire_pending = 1'b0; r1 = '0; r2 = '0;
        for (int cyc = 1; cyc <= W + 6; cyc++) begin
            if (cyc > 1) @(negedge Clk);
            if (fire_pending) begin in_valid = 1'b0; fire_pending = 1'b0; acc = cyc; end
            if (out_valid === 1'b1) begin
                pulses++;
                if (p1 < 0) begin p1 = cyc; r1 = ALUResult; end else begin p2 = cyc; r2 = ALUResult; end
            end
            if (in_valid && in_ready) fire_pending = 1'b1;
        end
        in_valid = 1'b0;
        m_hi = eh; m_lo = el;
        n_checks++; if (pulses != 2) begin n_errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
        n_checks++; if (p1 != W + 1 || p2 != W + 2) begin n_errors++; $display("FAIL b2b_timing got %0d/%0d exp %0d/%0d", p1, p2, W + 1, W + 2); end
        n_checks++; if (acc != W + 2) begin n_errors++; $display("FAIL b2b_accept got cycle %0d exp %0d", acc, W + 2); end
        n_checks++; if (r1 !== 32'd0 || r2 !== 32'd42) begin n_errors++; $display("FAIL b2b_results got %0d/%0d exp 0/42", r1, r2); end
        n_checks++; if (HI !== eh || LO !== el) begin n_errors++; $display("FAIL b2b_hilo got %h/%h exp %h/%h", HI, LO, eh, el); end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(5, 0))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(1000, 0));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_random;
        logic [3:0] op;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(11, 0));
            if (op == 4'd10) op = 4'd14;
            if (op == 4'd11) op = 4'd15;
            test_single("rand_alu", op, 32'($urandom), pick_operand(), 32'($urandom), 32'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                        5'($urandom), 26'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            op = 4'(10 + $urandom_range(3, 0));
            test_muldiv("rand_md", op, pick_operand(), pick_operand());
            if (i % 4 == 0)
                test_single("rand_mf", 4'(14 + $urandom_range(1, 0)), 32'd0, 32'd0, 32'd0, 32'd0,
                            1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 26'd0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_flags_shifts();
        test_mult_div();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_mdu_stage.md
Name: execute_mdu_stage

Overview:
Parametrised, registered successor to the single-cycle Execute stage. It adds the MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO registers and MFHI/MFLO. Sits between the ID/EX and EX/MEM pipeline registers and drives the pipeline stall while an iterative multiply or divide is in flight. All outputs are registered, so the block also forms the EX/MEM boundary for its own results.

Parameters:
DATA_W, 32, datapath width (even, >= 8)
REG_ADDR_W, 5, register index width
SHAMT_W, 5, shift-amount width (= clog2(DATA_W))
INDEX_W, 26, jump instr_index width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high
in_valid  in  1  ID/EX holds a valid instruction
in_ready  out  1  stage can accept this cycle (state IDLE)
Stall  out  1  = !in_ready; freezes IF/ID and ID/EX
ALUOp  in  4  operation select, encoding below
ALUSrc1  in  1  B operand: 0 = Reg_Data2, 1 = Imm32b
RegDst  in  1  destination: 0 = rt, 1 = rd
RegWrite_in  in  1  instruction writes the register file
Shamt  in  SHAMT_W  shift amount
Reg_Data1, Reg_Data2, Imm32b, PCPlusFour  in  DATA_W each  operands
rt, rd  in  REG_ADDR_W each  register indices
instr_index  in  INDEX_W  jump target field
out_valid  out  1  registered outputs are valid this cycle
ALUResult  out  DATA_W  result
Zero  out  1  ALUResult == 0
PC_Plus_Branch  out  DATA_W  PCPlusFour + (Imm32b << 2), truncated to DATA_W
j_sll_two  out  INDEX_W+2  {instr_index, 2'b00}
RegDestSelected  out  REG_ADDR_W  selected destination register
RegWrite_out  out  1  forwarded write enable; forced 0 for mult/div ops
HI, LO  out  DATA_W each  architectural HI/LO registers

Behaviour:
- ALUOp encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLL, 8 SRL, 9 SRA, 10 MULT, 11 MULTU, 12 DIV, 13 DIVU, 14 MFHI, 15 MFLO.
- Shifts: operate on B, shifted by Shamt. Arithmetic wraps modulo 2^DATA_W. Overflow is not trapped.
- Reset (async): state IDLE, counter 0, out_valid 0. All data outputs, HI and LO are 0. RegWrite_out 0.
- States:
  - IDLE: in_ready = 1.
  - MUL: iterative shift-add.
  - DIV: restoring divider.
- Transfer occurs on a rising edge where in_valid && in_ready.
- Ops 0-9, 14, 15 (single-cycle):
  - Results are registered on the transfer edge, so out_valid = 1 for exactly the next cycle.
  - State stays IDLE, so back-to-back transfers are allowed.
  - MFHI/MFLO return the HI/LO value present at the transfer edge.
- Ops 10-13 (multi-cycle):
  - Transfer edge captures the operands (signed ops take magnitudes and record result signs), loads counter = DATA_W, enters MUL or DIV, and sets out_valid = 0.
  - Counter decrements once per edge.
  - On the edge where counter == 1, HI/LO are written with the final values and state returns to IDLE.
  - out_valid = 1 for exactly the next cycle, with ALUResult = 0, RegWrite_out = 0 and RegDestSelected = 0.
  - Latency: HI/LO are updated DATA_W edges after the transfer edge. Stall is high for DATA_W cycles.
- MULT/MULTU: {HI, LO} = full 2*DATA_W-bit product.
- DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- Divide by zero (both signed and unsigned): LO = all ones, HI = dividend. Same latency as a normal divide.
- Signed overflow (DIV with most-negative / -1): LO = most-negative, HI = 0.
- in_valid while busy: ignored. Upstream holds its inputs until in_ready.
- Inputs changing while busy do not affect the in-flight operation.
- Reset asserted mid-operation: operation aborted, HI/LO cleared, no out_valid pulse.
- When out_valid = 0, the data outputs hold their last values.
- Zero, PC_Plus_Branch, j_sll_two and RegDestSelected are registered alongside ALUResult on single-cycle ops.

Test Plan:
1. ADD: A=108, B=112, RegDst=1, rd=16, Imm32b=15, PCPlusFour=4, instr_index=0x0FFFFFF -> next cycle: out_valid=1, ALUResult=220, Zero=0, RegDestSelected=16, PC_Plus_Branch=64, j_sll_two=0x3FFFFFC.
2. MULT: A=-3, B=7 -> Stall high 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, one out_valid pulse with RegWrite_out=0. A following MFLO returns 0xFFFFFFEB.
3. Division:
   - DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
   - DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
4. Reset during MULT (10 cycles after transfer) -> immediately Stall=0, out_valid=0, HI=LO=0. The next ADD completes normally.
5. Flags and shifts:
   - SUB 5-5 -> Zero=1.
   - SLT -1,1 -> 1.
   - SRA 0x80000000 by 4 -> 0xF8000000.
   - SRL by 4 -> 0x08000000.
6. Hold a SUB on in_valid during a DIVU -> SUB is accepted only on the first IDLE edge, and its out_valid follows the DIVU pulse by one cycle. Exactly one pulse per instruction.
